// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the MEM stage that completes each access after LATENCY wait cycles.
// The pipeline is held via stall_o while an access is in flight; done_o and err_o flag completion.
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             is_write_q;
  logic             misalign_q;
  logic             err_q;
  logic [CNT_W-1:0] count;
  logic             req;

  // Upper address bits alias onto the same words, so they are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:IDX_W+2];

  assign req = MemRead_i | MemWrite_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      data_o     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      count      <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q      <= addr_i[2 +: IDX_W];
            wdata_q    <= data_i;
            is_write_q <= MemWrite_i;
            misalign_q <= (addr_i[1:0] != 2'b00);
            err_q      <= (addr_i[1:0] != 2'b00) | (MemRead_i & MemWrite_i);
            count      <= CNT_W'(LATENCY - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (count == '0) begin
            // Commit edge: only the latched request matters; a misaligned access never touches memory.
            if (is_write_q) begin
              if (!misalign_q) begin
                mem[idx_q] <= wdata_q;
              end
            end else begin
              data_o <= misalign_q ? 32'h0 : mem[idx_q];
            end
            state <= RESP;
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall_o = (state == WAIT) | ((state == IDLE) & req);
  assign done_o  = (state == RESP);
  assign err_o   = (state == RESP) & err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench for dmem_wait_responder: directed test-plan steps followed by random
// accesses, all compared against a word-array reference model of the memory.
module tb_dmem_wait_responder;

  localparam int DEPTH_WORDS = 128;
  localparam int LATENCY     = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int passes = 0;

  logic [31:0] model_mem [DEPTH_WORDS];
  logic [31:0] model_data;

  dmem_wait_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .MemRead_i (MemRead_i),
    .MemWrite_i(MemWrite_i),
    .data_o    (data_o),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH_WORDS; i++) model_mem[i] = 32'h0;
    model_data = 32'h0;
  endtask

  // Drives one request, holds it through completion, and checks every cycle of it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int          idx;
    logic        mis;
    logic        exp_err;
    logic [31:0] prev_data;
    idx       = int'(addr[8:2]);
    mis       = (addr[1:0] != 2'b00);
    exp_err   = mis | (rd & wr);
    prev_data = model_data;
    if (wr) begin
      if (!mis) model_mem[idx] = data;
    end else begin
      model_data = mis ? 32'h0 : model_mem[idx];
    end
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = addr;
    data_i     = data;
    for (int c = 0; c <= LATENCY; c++) begin
      @(negedge clk_i);
      checkOutput("stall_busy", {31'b0, stall_o}, 32'd1);
      checkOutput("done_busy", {31'b0, done_o}, 32'd0);
      checkOutput("data_hold", data_o, prev_data);
      nextCycle();
    end
    @(negedge clk_i);
    checkOutput("done_resp", {31'b0, done_o}, 32'd1);
    checkOutput("stall_resp", {31'b0, stall_o}, 32'd0);
    checkOutput("err_resp", {31'b0, err_o}, {31'b0, exp_err});
    checkOutput("data_resp", data_o, model_data);
    nextCycle();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    checkOutput("done_idle", {31'b0, done_o}, 32'd0);
    checkOutput("stall_idle", {31'b0, stall_o}, 32'd0);
    nextCycle();
  endtask

  initial begin
    logic [7:0]  exp_stall;
    logic [7:0]  exp_done;
    logic        prev_done;
    logic [31:0] raddr;
    logic [31:0] rdata;
    int          op;

    rst_i      = 1'b1;
    addr_i     = 32'h0;
    data_i     = 32'h0;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    modelReset();
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_data", data_o, 32'h0);
    checkOutput("rst_stall", {31'b0, stall_o}, 32'd0);
    checkOutput("rst_done", {31'b0, done_o}, 32'd0);
    checkOutput("rst_err", {31'b0, err_o}, 32'd0);
    nextCycle();

    $display("[TB] write/read back");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);

    $display("[TB] misaligned read");
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);

    $display("[TB] dual op");
    applyStimulus(1'b1, 1'b1, 32'h24, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'h24, 32'h0);

    $display("[TB] reset abort");
    MemWrite_i = 1'b1;
    addr_i     = 32'h20;
    data_i     = 32'hCAFEF00D;
    @(negedge clk_i);
    checkOutput("abort_stall0", {31'b0, stall_o}, 32'd1);
    nextCycle();
    MemWrite_i = 1'b0;
    rst_i      = 1'b1;
    @(negedge clk_i);
    checkOutput("abort_stall1", {31'b0, stall_o}, 32'd1);
    nextCycle();
    rst_i = 1'b0;
    modelReset();
    @(negedge clk_i);
    checkOutput("abort_data", data_o, 32'h0);
    checkOutput("abort_stall", {31'b0, stall_o}, 32'd0);
    checkOutput("abort_done", {31'b0, done_o}, 32'd0);
    checkOutput("abort_err", {31'b0, err_o}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);

    $display("[TB] wrap-around");
    applyStimulus(1'b0, 1'b1, 32'h200, 32'hA5A5A5A5);
    applyStimulus(1'b1, 1'b0, 32'h000, 32'h0);

    $display("[TB] held request");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h600DF00D);
    exp_stall = 8'b0111_0111;
    exp_done  = 8'b1000_1000;
    prev_done = 1'b0;
    MemRead_i = 1'b1;
    addr_i    = 32'h10;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) MemRead_i = 1'b0;
      @(negedge clk_i);
      checkOutput("held_stall", {31'b0, stall_o}, {31'b0, exp_stall[c]});
      checkOutput("held_done", {31'b0, done_o}, {31'b0, exp_done[c]});
      checkOutput("held_no_double_done", {31'b0, done_o & prev_done}, 32'd0);
      if (exp_done[c]) checkOutput("held_data", data_o, 32'h600DF00D);
      prev_done = done_o;
      nextCycle();
    end
    model_data = 32'h600DF00D;

    $display("[TB] random accesses");
    for (int n = 0; n < 40; n++) begin
      raddr = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) raddr[1:0] = 2'($urandom_range(1, 3));
      rdata = $urandom;
      op    = int'($urandom_range(0, 3));
      case (op)
        0, 1:    applyStimulus(1'b1, 1'b0, raddr, rdata);
        2:       applyStimulus(1'b0, 1'b1, raddr, rdata);
        default: applyStimulus(1'b1, 1'b1, raddr, rdata);
      endcase
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) nextCycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Data-memory responder for the pipeline's MEM stage. It answers the MemRead_i/MemWrite_i/addr_i/data_i request set with a configurable number of wait states.
- It asserts stall_o so the pipeline freezes while an access is in flight.
- It replaces the single-cycle data memory when modelling slow memory, and gives the hazard/stall logic a real multi-cycle responder to test against.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words; must be a power of 2.
- LATENCY, 2, wait cycles before an access completes; must be >= 1.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- addr_i  input  32  byte address of the request.
- data_i  input  32  write data.
- MemRead_i  input  1  read request.
- MemWrite_i  input  1  write request.
- data_o  output  32  registered read data; holds the last completed read.
- stall_o  output  1  pipeline freeze; high while a request is pending and not yet complete.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  error flag; valid only while done_o=1.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset (takes priority over everything):
  - state=IDLE; data_o=0; stall_o=0; done_o=0; err_o=0; counter=0; latched request cleared.
  - All memory words cleared to 0.
- Word index = addr[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4 bytes.
- A request is present when (MemRead_i | MemWrite_i).
- State IDLE:
  - done_o=0.
  - stall_o = request present (combinational, same cycle).
  - On a request: latch addr, data, op and error flags; load counter with LATENCY-1; go to WAIT.
  - No request: stay in IDLE.
- Op and error rules at latch time:
  - MemWrite_i and MemRead_i both high: op=write, err flag set.
  - addr[1:0] != 0: misalign error set.
- State WAIT:
  - stall_o=1. Counter decrements each cycle.
  - At counter==0, on the clock edge:
    - Aligned write: mem[index] <= latched data.
    - Aligned read: data_o <= mem[index].
    - Misaligned (either op): no memory write; a read loads data_o <= 0.
  - Then go to RESP.
  - Inputs are ignored in WAIT; the latched copy is authoritative.
- State RESP:
  - stall_o=0, done_o=1, err_o = latched error (misalign or dual-op).
  - The pipeline advances on this edge. The request still on the inputs in this cycle is the completed one and is NOT re-accepted.
  - Go to IDLE unconditionally.
- Timing: request first seen in cycle T.
  - stall_o is high for cycles T..T+LATENCY.
  - done_o is high in cycle T+LATENCY+1.
  - Minimum spacing between accepted requests is LATENCY+2 cycles.
- data_o changes only on a completed read or on reset; writes never change it.
- Reset mid-operation (WAIT): the access is aborted, a pending write is not committed, and memory is cleared anyway.
- Reset in the same cycle as the commit edge: reset wins.
- No back-pressure other than stall_o; all outputs except stall_o in IDLE are registered state decodes.

Test Plan (DEPTH_WORDS=128, LATENCY=2):
- Write, then read back:
  - Write 0xDEADBEEF to addr 0x10 at cycle 0 -> stall_o=1 in cycles 0-2, done_o=1 in cycle 3, err_o=0.
  - Read 0x10 issued in cycle 4 -> data_o=0xDEADBEEF with done_o in cycle 7.
- Misaligned read of 0x13 after the write above -> done_o=1 with err_o=1, data_o=0; a later read of 0x10 still returns 0xDEADBEEF.
- Dual op: MemRead_i=MemWrite_i=1, addr 0x24, data 0x12345678 -> err_o=1 at done; a subsequent read of 0x24 returns 0x12345678.
- Reset abort: write 0xCAFEF00D to 0x20, pulse rst_i in cycle 1 (WAIT) -> all outputs 0 next cycle, state IDLE; a read of 0x20 returns 0.
- Wrap-around: write 0xA5A5A5A5 to 0x200 (word 128) -> a read of 0x000 returns 0xA5A5A5A5.
- Held request: keep MemRead_i=1 at 0x10 for cycles 0-6 ->
  - First done_o in cycle 3.
  - Cycle 4 (IDLE) accepts a new request, with stall_o=1 again in cycles 4-6.
  - Second done_o in cycle 7.
  - done_o is never high in two consecutive cycles.
